// File: rtl/cursor_action_unit.sv
// ---------------------------------------------------------------------------
// cursor_action_unit
//
// Executes VT100 cursor-positioning commands handed over by the CSI parser
// (CUP, CUU, CUD, CUF, CUB, CNL, CPL, CHA, VPA, DECSC, DECRC). The unit takes
// the current cursor position and the numeric parameters, and produces a new
// cursor position that is always clamped to the screen. It also holds one
// saved-cursor slot for DECSC/DECRC.
//
// Each command takes three cycles: IDLE (accept) -> EXEC (compute and
// register) -> DONE (result pulse) -> IDLE.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   cmd_valid      command and parameters valid
//   cmd_ready      unit idle, can accept a command
//   cmd_type       0 NOP, 1 CUP, 2 CUU, 3 CUD, 4 CUF, 5 CUB, 6 CNL, 7 CPL,
//                  8 CHA, 9 VPA, 10 DECSC, 11 DECRC, 12+ unsupported
//   pn1, pn2       CSI parameters, 1-based, 0 means 1
//   i_cursor_x/y   current cursor column/row, sampled on accept
//   o_cursor_x/y   registered new cursor column/row
//   o_update       one-cycle pulse, o_cursor_* carry a new result
//   o_unsupported  one-cycle pulse, the command code was rejected
// ---------------------------------------------------------------------------
module cursor_action_unit #(
   parameter int CONSOLE_LINES   = 24,
   parameter int CONSOLE_COLUMNS = 80,
   parameter int COORD_W         = 8,
   parameter int PARAM_W         = 8,
   parameter int CMD_W           = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [CMD_W-1:0]   cmd_type,
   input  logic [PARAM_W-1:0] pn1,
   input  logic [PARAM_W-1:0] pn2,
   input  logic [COORD_W-1:0] i_cursor_x,
   input  logic [COORD_W-1:0] i_cursor_y,
   output logic [COORD_W-1:0] o_cursor_x,
   output logic [COORD_W-1:0] o_cursor_y,
   output logic               o_update,
   output logic               o_unsupported
);

   // Arithmetic width wide enough that coordinate + parameter never wraps.
   localparam int SUM_W = COORD_W + PARAM_W + 1;

   localparam logic [COORD_W-1:0] MAX_X_C = COORD_W'(CONSOLE_COLUMNS - 1);
   localparam logic [COORD_W-1:0] MAX_Y_C = COORD_W'(CONSOLE_LINES - 1);
   localparam logic [SUM_W-1:0]   MAX_X_W = SUM_W'(CONSOLE_COLUMNS - 1);
   localparam logic [SUM_W-1:0]   MAX_Y_W = SUM_W'(CONSOLE_LINES - 1);

   localparam logic [CMD_W-1:0] CMD_NOP   = CMD_W'(0);
   localparam logic [CMD_W-1:0] CMD_CUP   = CMD_W'(1);
   localparam logic [CMD_W-1:0] CMD_CUU   = CMD_W'(2);
   localparam logic [CMD_W-1:0] CMD_CUD   = CMD_W'(3);
   localparam logic [CMD_W-1:0] CMD_CUF   = CMD_W'(4);
   localparam logic [CMD_W-1:0] CMD_CUB   = CMD_W'(5);
   localparam logic [CMD_W-1:0] CMD_CNL   = CMD_W'(6);
   localparam logic [CMD_W-1:0] CMD_CPL   = CMD_W'(7);
   localparam logic [CMD_W-1:0] CMD_CHA   = CMD_W'(8);
   localparam logic [CMD_W-1:0] CMD_VPA   = CMD_W'(9);
   localparam logic [CMD_W-1:0] CMD_DECSC = CMD_W'(10);
   localparam logic [CMD_W-1:0] CMD_DECRC = CMD_W'(11);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CMD_W-1:0]     cmd_q, cmd_d;
   logic [PARAM_W-1:0]   n1_q, n1_d;
   logic [PARAM_W-1:0]   n2_q, n2_d;
   logic [COORD_W-1:0]   cx_q, cx_d;
   logic [COORD_W-1:0]   cy_q, cy_d;
   logic [COORD_W-1:0]   saved_x_q, saved_x_d;
   logic [COORD_W-1:0]   saved_y_q, saved_y_d;
   logic [COORD_W-1:0]   out_x_q, out_x_d;
   logic [COORD_W-1:0]   out_y_q, out_y_d;
   logic                 update_q, update_d;
   logic                 unsup_q, unsup_d;

   logic                 accept;
   logic                 supported;
   logic [SUM_W-1:0]     cx_w, cy_w, n1_w, n2_w;
   logic [SUM_W-1:0]     res_x, res_y;

   assign cmd_ready     = (state_q == IDLE);
   assign accept        = cmd_valid && cmd_ready;
   assign o_cursor_x    = out_x_q;
   assign o_cursor_y    = out_y_q;
   assign o_update      = update_q;
   assign o_unsupported = unsup_q;

   // Sequencing: one command walks IDLE -> EXEC -> DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_valid) state_d = EXEC;
         EXEC:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture the command on accept. Parameters of 0 default to 1, and the
   // incoming cursor is clamped to the screen before any arithmetic so a
   // stale out-of-range position cannot leak into the result.
   always_comb begin
      cmd_d = cmd_q;
      n1_d  = n1_q;
      n2_d  = n2_q;
      cx_d  = cx_q;
      cy_d  = cy_q;
      if (accept) begin
         cmd_d = cmd_type;
         n1_d  = (pn1 == '0) ? PARAM_W'(1) : pn1;
         n2_d  = (pn2 == '0) ? PARAM_W'(1) : pn2;
         cx_d  = (i_cursor_x > MAX_X_C) ? MAX_X_C : i_cursor_x;
         cy_d  = (i_cursor_y > MAX_Y_C) ? MAX_Y_C : i_cursor_y;
      end
   end

   // Result datapath. Everything is widened so sums and 1-based conversions
   // cannot wrap; each result is then clamped back into the screen. n1/n2
   // are at least 1 here, so n-1 never underflows.
   always_comb begin
      cx_w      = SUM_W'(cx_q);
      cy_w      = SUM_W'(cy_q);
      n1_w      = SUM_W'(n1_q);
      n2_w      = SUM_W'(n2_q);
      res_x     = cx_w;
      res_y     = cy_w;
      supported = 1'b1;
      case (cmd_q)
         CMD_NOP: ;
         CMD_CUP: begin
            res_y = ((n1_w - 1) > MAX_Y_W) ? MAX_Y_W : (n1_w - 1);
            res_x = ((n2_w - 1) > MAX_X_W) ? MAX_X_W : (n2_w - 1);
         end
         CMD_CUU: res_y = (cy_w > n1_w) ? (cy_w - n1_w) : '0;
         CMD_CUD: res_y = ((cy_w + n1_w) > MAX_Y_W) ? MAX_Y_W : (cy_w + n1_w);
         CMD_CUF: res_x = ((cx_w + n1_w) > MAX_X_W) ? MAX_X_W : (cx_w + n1_w);
         CMD_CUB: res_x = (cx_w > n1_w) ? (cx_w - n1_w) : '0;
         CMD_CNL: begin
            res_y = ((cy_w + n1_w) > MAX_Y_W) ? MAX_Y_W : (cy_w + n1_w);
            res_x = '0;
         end
         CMD_CPL: begin
            res_y = (cy_w > n1_w) ? (cy_w - n1_w) : '0;
            res_x = '0;
         end
         CMD_CHA: res_x = ((n1_w - 1) > MAX_X_W) ? MAX_X_W : (n1_w - 1);
         CMD_VPA: res_y = ((n1_w - 1) > MAX_Y_W) ? MAX_Y_W : (n1_w - 1);
         CMD_DECSC: ;
         CMD_DECRC: begin
            res_x = SUM_W'(saved_x_q);
            res_y = SUM_W'(saved_y_q);
         end
         default: supported = 1'b0;
      endcase
   end

   // Commit in EXEC. An unsupported code leaves the cursor outputs alone and
   // raises o_unsupported instead of o_update during the DONE cycle.
   always_comb begin
      out_x_d   = out_x_q;
      out_y_d   = out_y_q;
      saved_x_d = saved_x_q;
      saved_y_d = saved_y_q;
      update_d  = 1'b0;
      unsup_d   = 1'b0;
      if (state_q == EXEC) begin
         update_d = supported;
         unsup_d  = !supported;
         if (supported) begin
            out_x_d = res_x[COORD_W-1:0];
            out_y_d = res_y[COORD_W-1:0];
         end
         if (cmd_q == CMD_DECSC) begin
            saved_x_d = cx_q;
            saved_y_d = cy_q;
         end
      end
   end

   // State and datapath registers. Reset drops any in-flight command
   // without producing a pulse and also clears the saved-cursor slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cmd_q     <= '0;
         n1_q      <= '0;
         n2_q      <= '0;
         cx_q      <= '0;
         cy_q      <= '0;
         saved_x_q <= '0;
         saved_y_q <= '0;
         out_x_q   <= '0;
         out_y_q   <= '0;
         update_q  <= 1'b0;
         unsup_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         n1_q      <= n1_d;
         n2_q      <= n2_d;
         cx_q      <= cx_d;
         cy_q      <= cy_d;
         saved_x_q <= saved_x_d;
         saved_y_q <= saved_y_d;
         out_x_q   <= out_x_d;
         out_y_q   <= out_y_d;
         update_q  <= update_d;
         unsup_q   <= unsup_d;
      end
   end

endmodule
